// File: rtl/rx_sync_pkg.sv
// Shared types and constants for the 8b/10b receive word-sync path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rx_sync_pkg;

    typedef enum logic [1:0] {
        LOS  = 2'd0,
        ACQ  = 2'd1,
        SYNC = 2'd2
    } sync_state_t;

    // K28.5 in both running disparities, bit a in position 9
    localparam logic [9:0] K285_RDN = 10'b0011111010;
    localparam logic [9:0] K285_RDP = 10'b1100000101;

    // Last value of the 0..9 symbol phase counter
    localparam logic [3:0] PHASE_LAST = 4'd9;

    function automatic logic is_k285(input logic [9:0] w);
        return (w == K285_RDN) || (w == K285_RDP);
    endfunction

endpackage

// File: rtl/rx_sync_ctrl_comma_detect.sv
// Flags a K28.5 comma (either disparity) in the 10-bit sliding window.
// Latency: combinational, zero cycles.
// Backpressure: none; evaluates the window every cycle.
module comma_detect
    import rx_sync_pkg::*;
(
    input  logic [9:0] data_in,
    output logic       comma
);

    assign comma = is_k285(data_in);

endmodule

// File: rtl/rx_sync_ctrl.sv
// Word-sync controller: finds K28.5 symbol phase, holds lock, strobes aligned symbols.
// Latency: state and outputs update on the same CRCLK edge that samples the window.
// Backpressure: none; the decoder must take every SYMBOL_CLK pulse.
module rx_sync_ctrl
    import rx_sync_pkg::*;
#(
    parameter int ACQ_COMMAS = 3,
    parameter int LOSS_ERRS  = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic       CRCLK,
    input  logic       Reset,
    input  logic [9:0] data_in,
    output logic       SYMBOL_CLK,
    output logic       RXVALID,
    output logic [9:0] symbol_out,
    output logic [1:0] sync_state,
    output logic       lock_loss
);

    localparam logic [3:0] ACQ_TH = 4'(ACQ_COMMAS);
    localparam logic [3:0] ERR_TH = 4'(LOSS_ERRS);
    localparam logic [9:0] TMO_TH = 10'(TIMEOUT);

    sync_state_t state;
    logic [3:0]  phase;
    logic [3:0]  acq_cnt;
    logic [3:0]  err_cnt;
    logic [9:0]  sym_cnt;

    logic        comma;
    logic        phase0;
    logic        aligned;
    logic        misaligned;
    logic [3:0]  phase_inc;
    logic [3:0]  acq_inc;
    logic [3:0]  err_inc;
    logic [9:0]  sym_inc;

    comma_detect u_comma_detect (
        .data_in (data_in),
        .comma   (comma)
    );

    assign phase0     = (phase == 4'd0);
    assign aligned    = comma && phase0;
    assign misaligned = comma && !phase0;

    // Saturating next values so no counter can wrap back below its threshold
    assign phase_inc = (phase == PHASE_LAST) ? 4'd0 : phase + 4'd1;
    assign acq_inc   = (acq_cnt == 4'hF) ? acq_cnt : acq_cnt + 4'd1;
    assign err_inc   = (err_cnt == 4'hF) ? err_cnt : err_cnt + 4'd1;
    assign sym_inc   = (sym_cnt == 10'h3FF) ? sym_cnt : sym_cnt + 10'd1;

    assign sync_state = state;

    // LOS/ACQ/SYNC machine with phase tracking, lock counters and registered outputs
    always_ff @(posedge CRCLK) begin
        if (!Reset) begin
            state      <= LOS;
            phase      <= 4'd0;
            acq_cnt    <= 4'd0;
            err_cnt    <= 4'd0;
            sym_cnt    <= 10'd0;
            SYMBOL_CLK <= 1'b0;
            RXVALID    <= 1'b0;
            symbol_out <= 10'd0;
            lock_loss  <= 1'b0;
        end else begin
            phase      <= phase_inc;
            SYMBOL_CLK <= 1'b0;
            lock_loss  <= 1'b0;
            case (state)
                LOS: begin
                    // Any comma fixes a candidate phase: this cycle becomes phase 0
                    if (comma) begin
                        phase   <= 4'd1;
                        acq_cnt <= 4'd1;
                        sym_cnt <= 10'd0;
                        state   <= ACQ;
                    end
                end
                ACQ: begin
                    if (aligned) begin
                        acq_cnt <= acq_inc;
                        sym_cnt <= 10'd0;
                        if (acq_inc >= ACQ_TH) begin
                            // The completing comma is the first delivered symbol
                            state      <= SYNC;
                            err_cnt    <= 4'd0;
                            RXVALID    <= 1'b1;
                            SYMBOL_CLK <= 1'b1;
                            symbol_out <= data_in;
                        end
                    end else if (misaligned) begin
                        phase   <= 4'd1;
                        acq_cnt <= 4'd1;
                        sym_cnt <= 10'd0;
                    end else if (phase0) begin
                        sym_cnt <= sym_inc;
                        if (sym_inc >= TMO_TH) begin
                            state <= LOS;
                        end
                    end
                end
                SYNC: begin
                    if (aligned) begin
                        err_cnt    <= 4'd0;
                        sym_cnt    <= 10'd0;
                        SYMBOL_CLK <= 1'b1;
                        symbol_out <= data_in;
                    end else if (misaligned) begin
                        // Locked phase is kept; stray commas only count as errors
                        err_cnt <= err_inc;
                        if (err_inc >= ERR_TH) begin
                            state     <= LOS;
                            RXVALID   <= 1'b0;
                            lock_loss <= 1'b1;
                        end
                    end else if (phase0) begin
                        sym_cnt <= sym_inc;
                        if (sym_inc >= TMO_TH) begin
                            // The sample that drops lock is not delivered
                            state     <= LOS;
                            RXVALID   <= 1'b0;
                            lock_loss <= 1'b1;
                        end else begin
                            SYMBOL_CLK <= 1'b1;
                            symbol_out <= data_in;
                        end
                    end
                end
                default: begin
                    state   <= LOS;
                    RXVALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Scoreboard bench for rx_sync_ctrl: directed comma patterns, expected output events queued.
// Latency: n/a.
// Backpressure: n/a.
module tb_rx_sync_ctrl;
    import rx_sync_pkg::*;

    localparam logic [9:0] IDLE = 10'b0101010101;
    localparam logic [9:0] D2   = 10'b1110001100;
    localparam int         LAST_CYC = 900;

    typedef struct packed {
        logic [15:0] edge_n;
        logic [1:0]  st;
        logic        rxv;
        logic        sclk;
        logic [9:0]  sym;
        logic        ll;
    } ev_t;

    logic       CRCLK = 1'b0;
    logic       Reset;
    logic [9:0] data_in;
    logic       SYMBOL_CLK;
    logic       RXVALID;
    logic [9:0] symbol_out;
    logic [1:0] sync_state;
    logic       lock_loss;

    ev_t        exp_q[$];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic       expect_idle = 1'b1;
    logic       done = 1'b0;
    logic [1:0] prev_st = 2'd0;
    logic       prev_rxv = 1'b0;

    rx_sync_ctrl #(
        .ACQ_COMMAS (3),
        .LOSS_ERRS  (4),
        .TIMEOUT    (64)
    ) dut (
        .CRCLK      (CRCLK),
        .Reset      (Reset),
        .data_in    (data_in),
        .SYMBOL_CLK (SYMBOL_CLK),
        .RXVALID    (RXVALID),
        .symbol_out (symbol_out),
        .sync_state (sync_state),
        .lock_loss  (lock_loss)
    );

    initial begin
        forever #5 CRCLK = ~CRCLK;
    end

    task automatic push(input int e, input logic [1:0] st, input logic rxv,
                        input logic sclk, input logic [9:0] sym, input logic ll);
        ev_t ev;
        ev.edge_n = 16'(e);
        ev.st     = st;
        ev.rxv    = rxv;
        ev.sclk   = sclk;
        ev.sym    = sym;
        ev.ll     = ll;
        exp_q.push_back(ev);
    endtask

    // One bit-clock cycle: window d is sampled by edge cyc+1
    task automatic drv(input logic [9:0] d);
        data_in = d;
        @(posedge CRCLK);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic idle_to(input int c_end, input logic [9:0] d);
        while (cyc < c_end) drv(d);
    endtask

    // Locked stretch without aligned commas: every phase-0 window is delivered
    task automatic sync_idle(input int c_end, input logic [9:0] d);
        while (cyc < c_end) begin
            if (cyc % 10 == 0) push(cyc + 1, SYNC, 1'b1, 1'b1, d, 1'b0);
            drv(d);
        end
    endtask

    // Stimulus with hand-derived expected events
    initial begin
        Reset   = 1'b0;
        data_in = K285_RDN;
        repeat (5) begin
            @(posedge CRCLK);
            data_in = (data_in == K285_RDN) ? K285_RDP : K285_RDN;
        end
        #1;
        data_in = K285_RDN;
        Reset   = 1'b1;

        // Acquisition: commas at cycles 20, 30, 40
        idle_to(20, IDLE);
        expect_idle = 1'b0;
        push(21, ACQ, 1'b0, 1'b0, 10'd0, 1'b0);
        drv(K285_RDN);
        idle_to(30, IDLE);
        drv(K285_RDN);
        idle_to(40, IDLE);
        push(41, SYNC, 1'b1, 1'b1, K285_RDN, 1'b0);
        drv(K285_RDN);
        idle_to(50, IDLE);
        push(51, SYNC, 1'b1, 1'b1, K285_RDP, 1'b0);
        drv(K285_RDP);

        // Three misaligned commas then an aligned one: lock must hold
        sync_idle(74, IDLE);
        drv(K285_RDN);
        sync_idle(84, IDLE);
        drv(K285_RDP);
        sync_idle(94, IDLE);
        drv(K285_RDN);
        sync_idle(100, IDLE);
        push(101, SYNC, 1'b1, 1'b1, K285_RDN, 1'b0);
        drv(K285_RDN);

        // Four consecutive misaligned commas at phase 4: lock lost after the 4th
        sync_idle(104, IDLE);
        drv(K285_RDN);
        sync_idle(114, IDLE);
        drv(K285_RDN);
        sync_idle(124, IDLE);
        drv(K285_RDN);
        sync_idle(134, IDLE);
        push(135, LOS, 1'b0, 1'b0, IDLE, 1'b1);
        drv(K285_RDN);

        // ACQ re-phase: misaligned comma at phase 7 after two aligned commas
        idle_to(143, IDLE);
        push(144, ACQ, 1'b0, 1'b0, IDLE, 1'b0);
        drv(K285_RDN);
        idle_to(153, IDLE);
        drv(K285_RDN);
        idle_to(160, IDLE);
        drv(K285_RDP);
        idle_to(170, IDLE);
        drv(K285_RDN);
        idle_to(180, IDLE);
        push(181, SYNC, 1'b1, 1'b1, K285_RDN, 1'b0);
        drv(K285_RDN);

        // No commas for 64 symbol periods: 63 deliveries then timeout
        sync_idle(820, D2);
        push(821, LOS, 1'b0, 1'b0, D2, 1'b1);
        drv(D2);

        // Re-acquire, then a one-cycle reset pulse while locked
        idle_to(830, D2);
        push(831, ACQ, 1'b0, 1'b0, D2, 1'b0);
        drv(K285_RDN);
        idle_to(840, IDLE);
        drv(K285_RDN);
        idle_to(850, IDLE);
        push(851, SYNC, 1'b1, 1'b1, K285_RDN, 1'b0);
        drv(K285_RDN);
        sync_idle(863, IDLE);
        Reset = 1'b0;
        push(864, LOS, 1'b0, 1'b0, 10'd0, 1'b0);
        drv(K285_RDN);
        Reset = 1'b1;

        // Acquisition restarts after release
        idle_to(874, IDLE);
        push(875, ACQ, 1'b0, 1'b0, 10'd0, 1'b0);
        drv(K285_RDP);
        idle_to(884, IDLE);
        drv(K285_RDN);
        idle_to(894, IDLE);
        push(895, SYNC, 1'b1, 1'b1, K285_RDN, 1'b0);
        drv(K285_RDN);
        idle_to(LAST_CYC, IDLE);
        done = 1'b1;
    end

    // Monitor: compares every output event against the head of the queue
    initial begin
        ev_t got;
        ev_t want;
        while (!done) begin
            @(negedge CRCLK);
            got.edge_n = 16'(cyc);
            got.st     = sync_state;
            got.rxv    = RXVALID;
            got.sclk   = SYMBOL_CLK;
            got.sym    = symbol_out;
            got.ll     = lock_loss;
            if (expect_idle) begin
                vectors++;
                if ({sync_state, RXVALID, SYMBOL_CLK, symbol_out, lock_loss} !== 15'd0) begin
                    miscompares++;
                    $display("FAIL quiet@edge%0d: got st=%0d rxv=%b sclk=%b sym=%b ll=%b, want all zero",
                             cyc, sync_state, RXVALID, SYMBOL_CLK, symbol_out, lock_loss);
                end
            end else if (SYMBOL_CLK === 1'b1 || lock_loss === 1'b1 ||
                         sync_state !== prev_st || RXVALID !== prev_rxv) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event@edge%0d: got st=%0d rxv=%b sclk=%b sym=%b ll=%b, want no event",
                             cyc, got.st, got.rxv, got.sclk, got.sym, got.ll);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        miscompares++;
                        $display("FAIL event@edge%0d: got edge=%0d st=%0d rxv=%b sclk=%b sym=%b ll=%b, want edge=%0d st=%0d rxv=%b sclk=%b sym=%b ll=%b",
                                 cyc, got.edge_n, got.st, got.rxv, got.sclk, got.sym, got.ll,
                                 want.edge_n, want.st, want.rxv, want.sclk, want.sym, want.ll);
                    end
                end
            end
            prev_st  = sync_state;
            prev_rxv = RXVALID;
        end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event: got nothing, want edge=%0d st=%0d rxv=%b sclk=%b sym=%b ll=%b",
                     want.edge_n, want.st, want.rxv, want.sclk, want.sym, want.ll);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got cyc=%0d, want %0d before time limit", cyc, LAST_CYC);
        $fatal(1, "time limit expired");
    end

endmodule
